vga_sync_gen: RTL and testbench

Raster timing generator for the 640x480 VGA pipeline, sitting directly upstream of the paddle/ball renderer. It produces the column/row counters that the renderer consumes. It also produces active-video and frame-start flags, and HSync/VSync delayed by a configurable number of cycles so they line up with the renderer's registered colour outputs at the connector.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_delay_line.sv | 50 +++++
 rtl/vga_sync_gen.sv | 138 +++++++++++++
 tb/tb_vga_sync_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared 640x480@60 raster constants, the coordinate type and the run-state
//   encoding. The renderer takes ACTIVE_COLS/ACTIVE_ROWS from here as well, so
//   both sides of the pipeline agree on the visible area.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Coordinate width: 10 bits covers 0..799 columns and 0..524 rows.
  localparam int COORD_W = 10;

  localparam int ACTIVE_COLS   = 640;
  localparam int ACTIVE_ROWS   = 480;
  localparam int TOTAL_COLS    = 800;
  localparam int TOTAL_ROWS    = 525;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_WIDTH  = 96;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_WIDTH  = 2;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_e;

  // True when lo <= value <= hi (unsigned coordinate compare).
  function automatic logic in_window(coord_t value, coord_t lo, coord_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// ---------------------------------------------------------------------------
// sync_delay_line
//   WIDTH-bit shift register of DEPTH stages used to retime the raw sync
//   decodes so they line up with the renderer's registered colour outputs.
//   DEPTH = 0 is a straight wire. Every stage resets to all-ones, which is
//   the inactive level of the active-low syncs.
//
//   Ports:
//     i_Clk   pixel clock, rising edge
//     i_Rst   asynchronous, active-high reset
//     i_data  raw bits entering the line
//     o_data  bits delayed by DEPTH clocks
// ---------------------------------------------------------------------------
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_data = i_data;
    end else begin : g_shift
      logic [DEPTH-1:0][WIDTH-1:0] r_stage;

      // NOTE: every stage gets an explicit reset value; without it the
      // connector would see undefined sync levels until DEPTH clocks after
      // reset.
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          r_stage <= '1;
        end else begin
          // NOTE: non-blocking assignments let every stage sample the old
          // value of its neighbour, so this really is a shift, not a copy.
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator for the 640x480 pipeline. After reset a two-state
//   run FSM starts the column/row counters; active-video, frame-start and the
//   raw syncs are decoded from the registered counters, and the syncs are
//   retimed by SYNC_DELAY (0..4) clocks to match the renderer's colour
//   register.
//
//   Ports:
//     i_Clk          pixel clock, rising edge
//     i_Rst          asynchronous, active-high reset
//     o_col_num      current column, 0..TOTAL_COLS-1
//     o_row_num      current row, 0..TOTAL_ROWS-1
//     o_active       inside the visible area (aligned with the counters)
//     o_frame_start  one-cycle pulse at column 0, row 0
//     o_HSync        horizontal sync, active-low, delayed SYNC_DELAY clocks
//     o_VSync        vertical sync, active-low, delayed SYNC_DELAY clocks
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int ACTIVE_COLS   = vga_timing_pkg::ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = vga_timing_pkg::ACTIVE_ROWS,
  parameter int TOTAL_COLS    = vga_timing_pkg::TOTAL_COLS,
  parameter int TOTAL_ROWS    = vga_timing_pkg::TOTAL_ROWS,
  parameter int H_FRONT_PORCH = vga_timing_pkg::H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH  = vga_timing_pkg::H_SYNC_WIDTH,
  parameter int V_FRONT_PORCH = vga_timing_pkg::V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH  = vga_timing_pkg::V_SYNC_WIDTH,
  parameter int SYNC_DELAY    = 1
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst,
  output logic [vga_timing_pkg::COORD_W-1:0] o_col_num,
  output logic [vga_timing_pkg::COORD_W-1:0] o_row_num,
  output logic                               o_active,
  output logic                               o_frame_start,
  output logic                               o_HSync,
  output logic                               o_VSync
);

  import vga_timing_pkg::*;

  localparam coord_t COL_LAST  = coord_t'(TOTAL_COLS - 1);
  localparam coord_t ROW_LAST  = coord_t'(TOTAL_ROWS - 1);
  localparam coord_t COL_VIS   = coord_t'(ACTIVE_COLS);
  localparam coord_t ROW_VIS   = coord_t'(ACTIVE_ROWS);
  localparam coord_t HS_FIRST  = coord_t'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam coord_t HS_LAST   = coord_t'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam coord_t VS_FIRST  = coord_t'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam coord_t VS_LAST   = coord_t'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  run_state_e r_run;
  run_state_e run_next;
  logic       running;

  coord_t     r_col_num;
  coord_t     r_row_num;

  logic       hsync_raw;
  logic       vsync_raw;
  logic [1:0] sync_dly;

  // Run FSM: state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_run <= IDLE;
    end else begin
      r_run <= run_next;
    end
  end

  // Run FSM: next state. Leaves IDLE on the first edge after reset release
  // and stays in RUN until the next reset.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps any path that
    // forgets an assignment from inferring a latch.
    run_next = r_run;
    unique case (r_run)
      IDLE:    run_next = RUN;
      RUN:     run_next = RUN;
      default: run_next = IDLE;
    endcase
  end

  // Run FSM: output decode.
  always_comb begin
    running = (r_run == RUN);
  end

  // Raster counters. They hold at 0 in IDLE, so the first RUN cycle still
  // presents column 0, row 0.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_col_num <= '0;
      r_row_num <= '0;
    end else if (running) begin
      if (r_col_num == COL_LAST) begin
        r_col_num <= '0;
        if (r_row_num == ROW_LAST) begin
          r_row_num <= '0;
        end else begin
          r_row_num <= r_row_num + coord_t'(1);
        end
      end else begin
        r_col_num <= r_col_num + coord_t'(1);
      end
    end
  end

  // Decodes of the registered counters, all forced inactive while idle.
  always_comb begin
    o_active      = 1'b0;
    o_frame_start = 1'b0;
    hsync_raw     = 1'b1;
    vsync_raw     = 1'b1;
    if (running) begin
      o_active      = (r_col_num < COL_VIS) && (r_row_num < ROW_VIS);
      o_frame_start = (r_col_num == '0) && (r_row_num == '0);
      hsync_raw     = !in_window(r_col_num, HS_FIRST, HS_LAST);
      vsync_raw     = !in_window(r_row_num, VS_FIRST, VS_LAST);
    end
  end

  sync_delay_line #(
    .WIDTH (2),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_data ({hsync_raw, vsync_raw}),
    .o_data (sync_dly)
  );

  assign o_col_num = r_col_num;
  assign o_row_num = r_row_num;
  assign o_HSync   = sync_dly[1];
  assign o_VSync   = sync_dly[0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Directed bench. Full-size 640x480 instances (SYNC_DELAY 0/1/3) cover the
//   first line and horizontal sync placement; a scaled raster (24x16 total,
//   16x12 visible) with the same structure covers whole-frame behaviour,
//   vertical sync placement and a mid-frame asynchronous reset.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  // Scaled raster: hsync cols 18..20, vsync rows 13..14, frame 384 clocks.
  localparam int SM_AC  = 16;
  localparam int SM_AR  = 12;
  localparam int SM_TC  = 24;
  localparam int SM_TR  = 16;
  localparam int SM_HFP = 2;
  localparam int SM_HSW = 3;
  localparam int SM_VFP = 1;
  localparam int SM_VSW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input int observed, input int expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Full-size instances.
  logic [9:0] dut_col, dut_row, d0_col, d0_row, d3_col, d3_row;
  logic       dut_act, dut_fs, dut_hs, dut_vs;
  logic       d0_act, d0_fs, d0_hs, d0_vs;
  logic       d3_act, d3_fs, d3_hs, d3_vs;

  // Scaled instances.
  logic [9:0] s0_col, s0_row, s1_col, s1_row, s3_col, s3_row;
  logic       s0_act, s0_fs, s0_hs, s0_vs;
  logic       s1_act, s1_fs, s1_hs, s1_vs;
  logic       s3_act, s3_fs, s3_hs, s3_vs;

  vga_sync_gen u_dut (
    .i_Clk(clk), .i_Rst(rst), .o_col_num(dut_col), .o_row_num(dut_row),
    .o_active(dut_act), .o_frame_start(dut_fs), .o_HSync(dut_hs), .o_VSync(dut_vs)
  );

  vga_sync_gen #(.SYNC_DELAY(0)) u_d0 (
    .i_Clk(clk), .i_Rst(rst), .o_col_num(d0_col), .o_row_num(d0_row),
    .o_active(d0_act), .o_frame_start(d0_fs), .o_HSync(d0_hs), .o_VSync(d0_vs)
  );

  vga_sync_gen #(.SYNC_DELAY(3)) u_d3 (
    .i_Clk(clk), .i_Rst(rst), .o_col_num(d3_col), .o_row_num(d3_row),
    .o_active(d3_act), .o_frame_start(d3_fs), .o_HSync(d3_hs), .o_VSync(d3_vs)
  );

  vga_sync_gen #(
    .ACTIVE_COLS(SM_AC), .ACTIVE_ROWS(SM_AR), .TOTAL_COLS(SM_TC), .TOTAL_ROWS(SM_TR),
    .H_FRONT_PORCH(SM_HFP), .H_SYNC_WIDTH(SM_HSW), .V_FRONT_PORCH(SM_VFP),
    .V_SYNC_WIDTH(SM_VSW), .SYNC_DELAY(0)
  ) u_s0 (
    .i_Clk(clk), .i_Rst(rst), .o_col_num(s0_col), .o_row_num(s0_row),
    .o_active(s0_act), .o_frame_start(s0_fs), .o_HSync(s0_hs), .o_VSync(s0_vs)
  );

  vga_sync_gen #(
    .ACTIVE_COLS(SM_AC), .ACTIVE_ROWS(SM_AR), .TOTAL_COLS(SM_TC), .TOTAL_ROWS(SM_TR),
    .H_FRONT_PORCH(SM_HFP), .H_SYNC_WIDTH(SM_HSW), .V_FRONT_PORCH(SM_VFP),
    .V_SYNC_WIDTH(SM_VSW), .SYNC_DELAY(1)
  ) u_s1 (
    .i_Clk(clk), .i_Rst(rst), .o_col_num(s1_col), .o_row_num(s1_row),
    .o_active(s1_act), .o_frame_start(s1_fs), .o_HSync(s1_hs), .o_VSync(s1_vs)
  );

  vga_sync_gen #(
    .ACTIVE_COLS(SM_AC), .ACTIVE_ROWS(SM_AR), .TOTAL_COLS(SM_TC), .TOTAL_ROWS(SM_TR),
    .H_FRONT_PORCH(SM_HFP), .H_SYNC_WIDTH(SM_HSW), .V_FRONT_PORCH(SM_VFP),
    .V_SYNC_WIDTH(SM_VSW), .SYNC_DELAY(3)
  ) u_s3 (
    .i_Clk(clk), .i_Rst(rst), .o_col_num(s3_col), .o_row_num(s3_row),
    .o_active(s3_act), .o_frame_start(s3_fs), .o_HSync(s3_hs), .o_VSync(s3_vs)
  );

  initial begin
    int dut_fall = -1, dut_rise = -1, dut_low = 0;
    int d0_fall = -1, d0_rise = -1, d3_fall = -1;
    logic dut_prev = 1'b1, d0_prev = 1'b1, d3_prev = 1'b1;
    int s0_vfall = -1, s1_vfall = -1, s3_vfall = -1;
    int s0_vlow = 0, s1_vlow = 0, s3_vlow = 0;
    logic s0_vprev = 1'b1, s1_vprev = 1'b1, s3_vprev = 1'b1;
    int fs_at[$];
    int act_cnt = 0, act_err = 0;
    int found = 0, rst_pulses = 0, rst_colerr = 0;

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check("rst_col", dut_col, 0);
    check("rst_row", dut_row, 0);
    check("rst_active", dut_act, 0);
    check("rst_frame_start", dut_fs, 0);
    check("rst_hsync", dut_hs, 1);
    check("rst_vsync", dut_vs, 1);
    check("rst_d3_hsync", d3_hs, 1);
    check("rst_s3_vsync", s3_vs, 1);

    rst = 1'b0;
    @(negedge clk);

    // ---- Run the first line (full size) and two+ frames (scaled) ----
    for (int c = 0; c < 820; c++) begin
      if (c == 0) begin
        check("start_frame_start", dut_fs, 1);
        check("start_col", dut_col, 0);
        check("start_row", dut_row, 0);
        check("start_active", dut_act, 1);
      end
      if (c == 1) check("second_col", dut_col, 1);
      if (c == 639) check("col639_active", dut_act, 1);
      if (c == 640) check("col640_active", dut_act, 0);
      if (c == 799) begin
        check("eol_col", dut_col, 799);
        check("eol_row", dut_row, 0);
      end
      if (c == 800) begin
        check("wrap_col", dut_col, 0);
        check("wrap_row", dut_row, 1);
        check("row1_frame_start", dut_fs, 0);
      end

      if (c < 800) begin
        if (!dut_hs && dut_prev && dut_fall < 0) dut_fall = int'(dut_col);
        if (dut_hs && !dut_prev && dut_rise < 0) dut_rise = int'(dut_col);
        if (!dut_hs) dut_low++;
        if (!d0_hs && d0_prev && d0_fall < 0) d0_fall = int'(d0_col);
        if (d0_hs && !d0_prev && d0_rise < 0) d0_rise = int'(d0_col);
        if (!d3_hs && d3_prev && d3_fall < 0) d3_fall = int'(d3_col);
      end
      dut_prev = dut_hs;
      d0_prev  = d0_hs;
      d3_prev  = d3_hs;

      // Scaled raster boundaries.
      if (c == 23) begin
        check("sm_eol_col", s1_col, 23);
        check("sm_eol_row", s1_row, 0);
      end
      if (c == 24) begin
        check("sm_wrap_col", s1_col, 0);
        check("sm_wrap_row", s1_row, 1);
      end
      if (c == 383) begin
        check("sm_last_col", s1_col, 23);
        check("sm_last_row", s1_row, 15);
      end
      if (c == 384) begin
        check("sm_frame_wrap_col", s1_col, 0);
        check("sm_frame_wrap_row", s1_row, 0);
      end

      if (s1_fs) fs_at.push_back(c);

      if (c < 384) begin
        if (s1_act) act_cnt++;
        if (s1_act != ((s1_col < 10'(SM_AC)) && (s1_row < 10'(SM_AR)))) act_err++;
        if (!s0_vs && s0_vprev && s0_vfall < 0) s0_vfall = c;
        if (!s1_vs && s1_vprev && s1_vfall < 0) s1_vfall = c;
        if (!s3_vs && s3_vprev && s3_vfall < 0) s3_vfall = c;
        if (!s0_vs) s0_vlow++;
        if (!s1_vs) s1_vlow++;
        if (!s3_vs) s3_vlow++;
      end
      s0_vprev = s0_vs;
      s1_vprev = s1_vs;
      s3_vprev = s3_vs;

      @(negedge clk);
    end

    // Horizontal sync placement at full size.
    check("hs_d1_fall_col", dut_fall, 657);
    check("hs_d1_rise_col", dut_rise, 753);
    check("hs_d1_low_clocks", dut_low, 96);
    check("hs_d0_fall_col", d0_fall, 656);
    check("hs_d0_rise_col", d0_rise, 752);
    check("hs_d3_fall_col", d3_fall, 659);
    check("vs_full_line0", dut_vs, 1);

    // Frame accounting on the scaled raster (row 13 col 0 is cycle 312).
    check("fs_pulse_count", fs_at.size(), 3);
    if (fs_at.size() == 3) begin
      check("fs_first", fs_at[0], 0);
      check("fs_gap1", fs_at[1] - fs_at[0], 384);
      check("fs_gap2", fs_at[2] - fs_at[1], 384);
    end
    check("active_count", act_cnt, 192);
    check("active_outside", act_err, 0);
    check("vs_d0_fall_cycle", s0_vfall, 312);
    check("vs_d1_fall_cycle", s1_vfall, 313);
    check("vs_d3_fall_cycle", s3_vfall, 315);
    check("vs_d0_low_clocks", s0_vlow, 48);
    check("vs_d1_low_clocks", s1_vlow, 48);
    check("vs_d3_low_clocks", s3_vlow, 48);

    // ---- Mid-frame asynchronous reset while both syncs are low ----
    for (int k = 0; k < 600; k++) begin
      if (s1_row == 10'd13 && s1_col == 10'd19) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("mid_reach", found, 1);
    check("mid_pre_hsync", s1_hs, 0);
    check("mid_pre_vsync", s1_vs, 0);
    check("mid_pre_s3_vsync", s3_vs, 0);

    #2 rst = 1'b1;
    #1;
    check("mid_col", s1_col, 0);
    check("mid_row", s1_row, 0);
    check("mid_active", s1_act, 0);
    check("mid_frame_start", s1_fs, 0);
    check("mid_hsync", s1_hs, 1);
    check("mid_vsync", s1_vs, 1);
    check("mid_s3_vsync", s3_vs, 1);
    check("mid_full_col", dut_col, 0);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (s1_fs || dut_fs) rst_pulses++;
      if (s1_col != 10'd0 || dut_col != 10'd0) rst_colerr++;
    end
    check("in_reset_pulses", rst_pulses, 0);
    check("in_reset_col_held", rst_colerr, 0);

    rst = 1'b0;
    @(negedge clk);
    check("restart_col", s1_col, 0);
    check("restart_row", s1_row, 0);
    check("restart_frame_start", s1_fs, 1);
    check("restart_active", s1_act, 1);
    check("restart_full_fs", dut_fs, 1);
    @(negedge clk);
    check("restart_next_col", s1_col, 1);
    check("restart_next_fs", s1_fs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
